// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer that shares one synchronous memory
// port between instruction fetch (I) and data access (D) requesters.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_done_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              owner_d_q, owner_d_d;   // 1 = current access belongs to D
  logic              last_d_q, last_d_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_d;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (if_req_i || d_req_i) begin
          // On a tie the port that was not served last wins.
          grant_d     = d_req_i && (!if_req_i || !last_d_q);
          owner_d_d   = grant_d;
          last_d_d    = grant_d;
          mem_we_d    = grant_d && d_we_i;
          mem_addr_d  = grant_d ? d_addr_i : if_addr_i;
          mem_wdata_d = grant_d ? d_wdata_i : '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          if (!owner_d_q) begin
            if_rdata_d = mem_rdata_i;
          end else if (!mem_we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      owner_d_q   <= 1'b0;
      last_d_q    <= 1'b0;
      cnt_q       <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Strobes are decoded from state only, so no input reaches an output.
  assign mem_en_o    = (state_q == S_ISSUE);
  assign busy_o      = (state_q != S_IDLE);
  assign if_done_o   = (state_q == S_DONE) && !owner_d_q;
  assign d_done_o    = (state_q == S_DONE) && owner_d_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three builds (MEM_LAT 2, 1, 15) each
// with a latency memory, a request-level reference model and random traffic.
module tb_mem_port_arbiter;
  localparam int N_INST = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass = 0;
  int n_inst_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  typedef struct {
    bit          is_d;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          issue_cyc;
    int          done_cyc;
  } exp_t;

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam int L      = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    localparam int BUDGET = 3 * (L + 3) + 8;

    logic        rst_n = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        if_done, d_done, mem_en, mem_we, busy;
    logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(L)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_done_o(d_done), .d_rdata_o(d_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: valid data only in the last cycle of the latency window.
    logic [63:0] env_mem [logic [63:0]];
    int          rd_cyc = -1;
    logic [63:0] rd_addr = '0;
    always @(negedge clk) begin
      if (mem_en) begin
        rd_cyc  = cyc + L;
        rd_addr = mem_addr;
        if (mem_we) env_mem[mem_addr] = mem_wdata;
      end
      if (cyc == rd_cyc)
        mem_rdata = env_mem.exists(rd_addr) ? env_mem[rd_addr] : init_word(rd_addr);
      else
        mem_rdata = {$urandom, $urandom};
    end

    // Reference model: accesses are serialized; each takes L+3 cycles from
    // the IDLE cycle in which it is picked.
    logic [63:0] ref_mem [logic [63:0]];
    exp_t        sb_q[$];
    int          free_cyc = 0, last_issue = -100;
    bit          model_last_d = 1'b0;
    logic [63:0] model_if_rdata = '0, model_d_rdata = '0;
    int          i_done_cnt = 0, d_done_cnt = 0, issue_cnt = 0;
    bit          in_reset_seen = 1'b0;

    always @(negedge clk) begin : monitor
      exp_t e;
      bit   exp_en, exp_busy, exp_idone, exp_ddone;
      if (!rst_n) begin
        if (!in_reset_seen) begin
          check($sformatf("L%0d reset strobes", L), {59'd0, mem_en, mem_we, if_done, d_done, busy}, 64'd0);
          check($sformatf("L%0d reset if_rdata", L), if_rdata, 64'd0);
          check($sformatf("L%0d reset d_rdata", L), d_rdata, 64'd0);
          check($sformatf("L%0d reset mem_addr", L), mem_addr | mem_wdata, 64'd0);
        end
        in_reset_seen  = 1'b1;
        sb_q.delete();
        free_cyc       = 0;
        last_issue     = -100;
        model_last_d   = 1'b0;
        model_if_rdata = '0;
        model_d_rdata  = '0;
      end else begin
        in_reset_seen = 1'b0;
        exp_busy = sb_q.size() > 0 && cyc >= sb_q[0].issue_cyc;
        exp_en   = sb_q.size() > 0 && cyc == sb_q[0].issue_cyc;
        if (busy || exp_busy) check($sformatf("L%0d busy @%0d", L, cyc), busy, exp_busy);
        if (mem_en || exp_en) begin
          check($sformatf("L%0d mem_en @%0d", L, cyc), mem_en, exp_en);
          if (exp_en) begin
            check($sformatf("L%0d mem_we", L), mem_we, sb_q[0].we);
            check($sformatf("L%0d mem_addr", L), mem_addr, sb_q[0].addr);
            check($sformatf("L%0d mem_wdata", L), mem_wdata, sb_q[0].wdata);
            check($sformatf("L%0d issue spacing ok", L), (cyc - last_issue) >= L + 3, 1);
            last_issue = cyc;
          end
        end
        if (mem_en) issue_cnt++;
        exp_idone = sb_q.size() > 0 && cyc == sb_q[0].done_cyc && !sb_q[0].is_d;
        exp_ddone = sb_q.size() > 0 && cyc == sb_q[0].done_cyc && sb_q[0].is_d;
        if (if_done || exp_idone) check($sformatf("L%0d if_done @%0d", L, cyc), if_done, exp_idone);
        if (d_done || exp_ddone) check($sformatf("L%0d d_done @%0d", L, cyc), d_done, exp_ddone);
        if (exp_idone || exp_ddone) begin
          e = sb_q.pop_front();
          if (!e.is_d) model_if_rdata = e.rdata;
          else if (!e.we) model_d_rdata = e.rdata;
          check($sformatf("L%0d if_rdata", L), if_rdata, model_if_rdata);
          check($sformatf("L%0d d_rdata", L), d_rdata, model_d_rdata);
        end
        if (if_done) i_done_cnt++;
        if (d_done) d_done_cnt++;

        // Arbitration decision for the grant edge at the end of this cycle.
        if (cyc >= free_cyc && (if_req || d_req)) begin
          if (if_req && d_req) e.is_d = !model_last_d;
          else e.is_d = d_req;
          model_last_d = e.is_d;
          e.we    = e.is_d && d_we;
          e.addr  = e.is_d ? d_addr : if_addr;
          e.wdata = e.is_d ? d_wdata : 64'd0;
          if (e.we) begin
            ref_mem[e.addr] = e.wdata;
            e.rdata = '0;
          end else begin
            e.rdata = ref_mem.exists(e.addr) ? ref_mem[e.addr] : init_word(e.addr);
          end
          e.issue_cyc = cyc + 1;
          e.done_cyc  = cyc + L + 2;
          free_cyc    = cyc + L + 3;
          sb_q.push_back(e);
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    function automatic int evt_cnt(input int which);
      case (which)
        0:       return i_done_cnt;
        1:       return d_done_cnt;
        2:       return issue_cnt;
        default: return i_done_cnt + d_done_cnt;
      endcase
    endfunction

    task automatic wait_evt(input int which, input int n, input string what);
      int start;
      start = evt_cnt(which);
      for (int k = 0; k < n * BUDGET && evt_cnt(which) - start < n; k++) tick();
      check($sformatf("L%0d %s", L, what), evt_cnt(which) - start, n);
    endtask

    task automatic new_payload(input bit is_d);
      if (is_d) begin
        d_addr  = 64'h100 + 64'($urandom_range(0, 7)) * 8;
        d_we    = $urandom_range(0, 1) == 1;
        d_wdata = {$urandom, $urandom};
      end else begin
        if_addr = 64'h100 + 64'($urandom_range(0, 7)) * 8;
      end
    endtask

    task automatic set_req(input bit is_d, input bit v);
      if (is_d) d_req = v;
      else if_req = v;
    endtask

    task automatic rand_port(input bit is_d, input int ncyc);
      int seen, now;
      seen = is_d ? d_done_cnt : i_done_cnt;
      for (int k = 0; k < ncyc; k++) begin
        tick();
        now = is_d ? d_done_cnt : i_done_cnt;
        if (is_d ? d_req : if_req) begin
          if (now != seen) begin
            if ($urandom_range(0, 3) != 0) set_req(is_d, 1'b0);
            else new_payload(is_d);
          end else if ($urandom_range(0, 15) == 0) begin
            set_req(is_d, 1'b0);
          end else if ($urandom_range(0, 7) == 0) begin
            new_payload(is_d);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_payload(is_d);
          set_req(is_d, 1'b1);
        end
        seen = now;
      end
      set_req(is_d, 1'b0);
    endtask

    initial begin : driver
      env_mem[64'h40] = 64'hD503201F;
      ref_mem[64'h40] = 64'hD503201F;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Single fetch.
      if_addr = 64'h40;
      if_req  = 1'b1;
      wait_evt(0, 1, "fetch done");
      if_req = 1'b0;
      check($sformatf("L%0d fetch word", L), if_rdata, 64'hD503201F);
      check($sformatf("L%0d no d_done on fetch", L), d_done_cnt, 0);
      tick();

      // Store then load of the same word.
      d_addr = 64'h100; d_we = 1'b1; d_wdata = 64'hDEADBEEF; d_req = 1'b1;
      wait_evt(1, 1, "store done");
      d_req = 1'b0;
      check($sformatf("L%0d d_rdata kept on store", L), d_rdata, 64'd0);
      tick();
      d_we = 1'b0; d_req = 1'b1;
      wait_evt(1, 1, "load done");
      d_req = 1'b0;
      check($sformatf("L%0d load after store", L), d_rdata, 64'hDEADBEEF);
      tick();

      // D request raised while the fetch is already in WAIT.
      if_addr = 64'h48; if_req = 1'b1;
      wait_evt(2, 1, "late fetch issued");
      d_addr = 64'h100; d_we = 1'b0; d_req = 1'b1;
      wait_evt(0, 1, "late fetch done");
      if_req = 1'b0;
      check($sformatf("L%0d late D not done before I", L), d_done_cnt, 2);
      wait_evt(1, 1, "late load done");
      d_req = 1'b0;
      tick();

      // Reset asserted in the middle of an access.
      if_addr = 64'h50; if_req = 1'b1;
      wait_evt(2, 1, "abandoned fetch issued");
      #1 rst_n = 1'b0;
      #1;
      check($sformatf("L%0d busy drops in reset", L), {mem_en, busy, if_done, d_done}, 4'd0);
      if_req = 1'b0;
      tick();
      tick();
      @(posedge clk);
      #1 rst_n = 1'b1;
      check($sformatf("L%0d if_rdata cleared", L), if_rdata, 64'd0);
      check($sformatf("L%0d d_rdata cleared", L), d_rdata, 64'd0);

      // Contention straight after reset: D, I, D, I.
      if_addr = 64'h60; d_addr = 64'h108; d_we = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      wait_evt(3, 4, "contention dones");
      if_req = 1'b0; d_req = 1'b0;
      check($sformatf("L%0d contention I count", L), i_done_cnt, 4);
      check($sformatf("L%0d contention D count", L), d_done_cnt, 5);
      tick();

      // Random traffic on both ports.
      fork
        rand_port(1'b0, 40 * (L + 3));
        rand_port(1'b1, 40 * (L + 3));
      join
      repeat (L + 6) tick();
      check($sformatf("L%0d scoreboard drained", L), sb_q.size(), 0);
      n_inst_done++;
    end
  end

  initial begin : finisher
    fork
      wait (n_inst_done == N_INST);
      #500_000;
    join_any
    disable fork;
    check("all builds finished", n_inst_done, N_INST);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
